// File: rtl/frog_hop_ctrl.sv
// Frog movement and life-cycle controller: button-driven animated grid hops,
// death/respawn sequencing, goal scoring and game-over/restart.
module frog_hop_ctrl #(
   parameter int unsigned H_WIDTH      = 11,
   parameter int unsigned H_HEIGHT     = 11,
   parameter int unsigned IX           = 320,
   parameter int unsigned IY           = 456,
   parameter int unsigned HOP_PIX      = 3,
   parameter int unsigned HOP_FRAMES   = 8,
   parameter int unsigned COOL_FRAMES  = 4,
   parameter int unsigned DEATH_FRAMES = 60,
   parameter int unsigned LIVES        = 3,
   parameter int unsigned GOAL_Y       = 24,
   parameter int unsigned D_WIDTH      = 640,
   parameter int unsigned D_HEIGHT     = 480
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ani_stb,
   input  logic        i_animate,
   input  logic        i_up_btn,
   input  logic        i_down_btn,
   input  logic        i_left_btn,
   input  logic        i_right_btn,
   input  logic        i_start_btn,
   input  logic        i_hit,
   output logic [11:0] o_x1,
   output logic [11:0] o_x2,
   output logic [11:0] o_y1,
   output logic [11:0] o_y2,
   output logic [1:0]  o_lives,
   output logic [7:0]  o_score,
   output logic        o_busy,
   output logic        o_dead,
   output logic        o_game_over
);

   localparam int unsigned PW   = 12;
   localparam int unsigned CW   = 8;
   localparam int unsigned BW   = 5;
   localparam int unsigned STEP = HOP_PIX * HOP_FRAMES;

   localparam int unsigned B_START = 4;
   localparam int unsigned B_UP    = 3;
   localparam int unsigned B_DOWN  = 2;
   localparam int unsigned B_LEFT  = 1;
   localparam int unsigned B_RIGHT = 0;

   typedef enum logic [2:0] {IDLE, HOP, COOLDOWN, DYING, GAME_OVER} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   state_t        state;
   dir_t          dir;
   dir_t          req_dir;
   logic          req_ok;
   logic [PW-1:0] x;
   logic [PW-1:0] y;
   logic [PW-1:0] x_step;
   logic [PW-1:0] y_step;
   logic [CW-1:0] cnt;
   logic [BW-1:0] sync_a;
   logic [BW-1:0] sync_b;
   logic [BW-1:0] pressed;
   logic          tick;
   logic          up_ok;
   logic          down_ok;
   logic          left_ok;
   logic          right_ok;

   assign pressed = ~sync_b;
   assign tick    = i_ani_stb & i_animate;

   // Box is a fixed offset of the registered centre
   assign o_x1 = x - PW'(H_WIDTH);
   assign o_x2 = x + PW'(H_WIDTH);
   assign o_y1 = y - PW'(H_HEIGHT);
   assign o_y2 = y + PW'(H_HEIGHT);

   assign up_ok    = y >= PW'(STEP + H_HEIGHT);
   assign down_ok  = (y + PW'(STEP + H_HEIGHT)) <= PW'(D_HEIGHT - 1);
   assign left_ok  = x >= PW'(STEP + H_WIDTH);
   assign right_ok = (x + PW'(STEP + H_WIDTH)) <= PW'(D_WIDTH - 1);

   // Only the highest-priority pressed direction is considered
   always_comb begin
      req_dir = DIR_UP;
      req_ok  = 1'b0;
      if (pressed[B_UP]) begin
         req_dir = DIR_UP;
         req_ok  = up_ok;
      end else if (pressed[B_DOWN]) begin
         req_dir = DIR_DOWN;
         req_ok  = down_ok;
      end else if (pressed[B_LEFT]) begin
         req_dir = DIR_LEFT;
         req_ok  = left_ok;
      end else if (pressed[B_RIGHT]) begin
         req_dir = DIR_RIGHT;
         req_ok  = right_ok;
      end
   end

   always_comb begin
      x_step = x;
      y_step = y;
      case (dir)
         DIR_UP:    y_step = y - PW'(HOP_PIX);
         DIR_DOWN:  y_step = y + PW'(HOP_PIX);
         DIR_LEFT:  x_step = x - PW'(HOP_PIX);
         DIR_RIGHT: x_step = x + PW'(HOP_PIX);
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         dir         <= DIR_UP;
         x           <= PW'(IX);
         y           <= PW'(IY);
         cnt         <= '0;
         sync_a      <= '1;
         sync_b      <= '1;
         o_lives     <= 2'(LIVES);
         o_score     <= '0;
         o_busy      <= 1'b0;
         o_dead      <= 1'b0;
         o_game_over <= 1'b0;
      end else begin
         sync_a <= {i_start_btn, i_up_btn, i_down_btn, i_left_btn, i_right_btn};
         sync_b <= sync_a;
         case (state)
            IDLE: begin
               if (tick) begin
                  if (i_hit) begin
                     state  <= DYING;
                     cnt    <= '0;
                     o_dead <= 1'b1;
                  end else if (req_ok) begin
                     state  <= HOP;
                     dir    <= req_dir;
                     cnt    <= '0;
                     o_busy <= 1'b1;
                  end
               end
            end
            HOP: begin
               if (tick) begin
                  if (i_hit) begin
                     state  <= DYING;
                     cnt    <= '0;
                     o_busy <= 1'b0;
                     o_dead <= 1'b1;
                  end else if (cnt == CW'(HOP_FRAMES - 1)) begin
                     state  <= COOLDOWN;
                     cnt    <= '0;
                     o_busy <= 1'b0;
                     if (y_step == PW'(GOAL_Y)) begin
                        if (o_score != 8'hFF) o_score <= o_score + 8'd1;
                        x <= PW'(IX);
                        y <= PW'(IY);
                     end else begin
                        x <= x_step;
                        y <= y_step;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                     x   <= x_step;
                     y   <= y_step;
                  end
               end
            end
            COOLDOWN: begin
               if (tick) begin
                  if (i_hit) begin
                     state  <= DYING;
                     cnt    <= '0;
                     o_dead <= 1'b1;
                  end else if (cnt == CW'(COOL_FRAMES - 1)) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            DYING: begin
               if (tick) begin
                  if (cnt == CW'(DEATH_FRAMES - 1)) begin
                     cnt     <= '0;
                     o_dead  <= 1'b0;
                     o_lives <= o_lives - 2'd1;
                     if (o_lives == 2'd1) begin
                        state       <= GAME_OVER;
                        o_game_over <= 1'b1;
                     end else begin
                        state <= IDLE;
                        x     <= PW'(IX);
                        y     <= PW'(IY);
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            GAME_OVER: begin
               if (pressed[B_START]) begin
                  state       <= IDLE;
                  o_lives     <= 2'(LIVES);
                  o_score     <= '0;
                  x           <= PW'(IX);
                  y           <= PW'(IY);
                  o_game_over <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Randomized scoreboard bench for frog_hop_ctrl against a tick-level
// behavioural model of the frog's position, lives, score and mode.
module tb_frog_hop_ctrl;

   localparam int HW = 11, HH = 11, IX = 320, IY = 456;
   localparam int HOP_PIX = 3, HOP_FRAMES = 8, STEP = 24;
   localparam int COOL_FRAMES = 4, DEATH_FRAMES = 60, LIVES = 3;
   localparam int GOAL_Y = 24, DW = 640, DH = 480;
   localparam int NCYC = 14000;

   localparam int MD_IDLE = 0, MD_HOP = 1, MD_COOL = 2, MD_DEAD = 3, MD_OVER = 4;

   typedef struct packed {
      logic [11:0] x1;
      logic [11:0] x2;
      logic [11:0] y1;
      logic [11:0] y2;
      logic [1:0]  lives;
      logic [7:0]  score;
      logic        busy;
      logic        dead;
      logic        go;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n, ani_stb, animate, hit;
   logic up_btn, down_btn, left_btn, right_btn, start_btn;
   logic [11:0] x1, x2, y1, y2;
   logic [1:0]  lives;
   logic [7:0]  score;
   logic        busy, dead, game_over;

   int   checks = 0;
   int   failures = 0;
   bit   drive_done = 0;
   obs_t exp_q[$];

   // Reference model state
   int   m_x, m_y, m_lives, m_score, m_mode, m_left, m_ux, m_uy;
   logic [4:0] m_s1, m_s2;
   int   goals_seen = 0, overs_seen = 0;

   frog_hop_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ani_stb   (ani_stb),
      .i_animate   (animate),
      .i_up_btn    (up_btn),
      .i_down_btn  (down_btn),
      .i_left_btn  (left_btn),
      .i_right_btn (right_btn),
      .i_start_btn (start_btn),
      .i_hit       (hit),
      .o_x1        (x1),
      .o_x2        (x2),
      .o_y1        (y1),
      .o_y2        (y2),
      .o_lives     (lives),
      .o_score     (score),
      .o_busy      (busy),
      .o_dead      (dead),
      .o_game_over (game_over)
   );

   always #5 clk = ~clk;

   function automatic obs_t model_obs();
      obs_t o;
      o.x1    = 12'(m_x - HW);
      o.x2    = 12'(m_x + HW);
      o.y1    = 12'(m_y - HH);
      o.y2    = 12'(m_y + HH);
      o.lives = 2'(m_lives);
      o.score = 8'(m_score);
      o.busy  = (m_mode == MD_HOP);
      o.dead  = (m_mode == MD_DEAD);
      o.go    = (m_mode == MD_OVER);
      return o;
   endfunction

   task automatic start_dying();
      m_mode = MD_DEAD;
      m_left = DEATH_FRAMES;
   endtask

   // One clock edge of the game rules; raw = {start,up,down,left,right}, active-low
   task automatic model_step(input logic r_n, input logic tk, input logic h,
                             input logic [4:0] raw);
      logic [4:0] prs;
      int ux, uy, nx, ny;
      if (!r_n) begin
         m_x = IX; m_y = IY; m_lives = LIVES; m_score = 0;
         m_mode = MD_IDLE; m_left = 0; m_s1 = '1; m_s2 = '1;
         return;
      end
      prs  = ~m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      case (m_mode)
         MD_IDLE: if (tk) begin
            if (h) start_dying();
            else begin
               ux = 0; uy = 0;
               if (prs[3])      uy = -1;
               else if (prs[2]) uy = 1;
               else if (prs[1]) ux = -1;
               else if (prs[0]) ux = 1;
               nx = m_x + ux * STEP;
               ny = m_y + uy * STEP;
               if ((ux != 0 || uy != 0) && nx - HW >= 0 && nx + HW <= DW - 1 &&
                   ny - HH >= 0 && ny + HH <= DH - 1) begin
                  m_mode = MD_HOP; m_left = HOP_FRAMES; m_ux = ux; m_uy = uy;
               end
            end
         end
         MD_HOP: if (tk) begin
            if (h) start_dying();
            else begin
               m_x = m_x + m_ux * HOP_PIX;
               m_y = m_y + m_uy * HOP_PIX;
               m_left--;
               if (m_left == 0) begin
                  if (m_y == GOAL_Y) begin
                     m_score = (m_score < 255) ? m_score + 1 : 255;
                     m_x = IX; m_y = IY;
                     goals_seen++;
                  end
                  m_mode = MD_COOL; m_left = COOL_FRAMES;
               end
            end
         end
         MD_COOL: if (tk) begin
            if (h) start_dying();
            else begin
               m_left--;
               if (m_left == 0) m_mode = MD_IDLE;
            end
         end
         MD_DEAD: if (tk) begin
            m_left--;
            if (m_left == 0) begin
               m_lives--;
               if (m_lives == 0) begin
                  m_mode = MD_OVER;
                  overs_seen++;
               end else begin
                  m_mode = MD_IDLE; m_x = IX; m_y = IY;
               end
            end
         end
         MD_OVER: if (prs[4]) begin
            m_lives = LIVES; m_score = 0; m_x = IX; m_y = IY; m_mode = MD_IDLE;
         end
         default: ;
      endcase
   endtask

   // Stimulus: drive at negedge, predict the post-edge outputs, queue them
   initial begin
      logic [4:0] raw;
      bit hop_rst_done, dead_rst_done;
      raw = '1;
      hop_rst_done = 0; dead_rst_done = 0;
      rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b1; hit = 1'b0;
      {start_btn, up_btn, down_btn, left_btn, right_btn} = raw;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         rst_n   = (c >= 3);
         ani_stb = ($urandom_range(1, 0) == 1);
         animate = ($urandom_range(15, 0) != 0);
         hit     = 1'b0;
         if (c < 4000) begin
            // Up held throughout, other buttons random: climbs to the goal row
            if ($urandom_range(30, 0) == 0) raw = 5'($urandom_range(31, 0));
            raw[3] = 1'b0;
            raw[4] = 1'b1;
         end else begin
            if ($urandom_range(40, 0) == 0) begin
               for (int b = 0; b < 4; b++) raw[b] = ($urandom_range(2, 0) != 0);
               raw[4] = ($urandom_range(7, 0) != 0);
            end
            hit = ($urandom_range(60, 0) == 0);
            if (c >= 9000 && c < 9300) animate = 1'b0;
            if (!hop_rst_done && m_mode == MD_HOP && m_left < HOP_FRAMES - 2) begin
               rst_n = 1'b0; hop_rst_done = 1;
            end else if (!dead_rst_done && m_mode == MD_DEAD && m_left < 30) begin
               rst_n = 1'b0; dead_rst_done = 1;
            end else if ($urandom_range(2500, 0) == 0) begin
               rst_n = 1'b0;
            end
         end
         {start_btn, up_btn, down_btn, left_btn, right_btn} = raw;
         model_step(rst_n, ani_stb & animate, hit, raw);
         exp_q.push_back(model_obs());
      end
      drive_done = 1;
   end

   // Monitor: compare DUT outputs one step after each queued prediction
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{x1: x1, x2: x2, y1: y1, y2: y2, lives: lives, score: score,
                  busy: busy, dead: dead, go: game_over};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL outputs t=%0t got x1=%0d x2=%0d y1=%0d y2=%0d lives=%0d score=%0d busy=%b dead=%b go=%b exp x1=%0d x2=%0d y1=%0d y2=%0d lives=%0d score=%0d busy=%b dead=%b go=%b",
                        $time, a.x1, a.x2, a.y1, a.y2, a.lives, a.score, a.busy, a.dead, a.go,
                        e.x1, e.x2, e.y1, e.y2, e.lives, e.score, e.busy, e.dead, e.go);
            end
         end
      end
   end

   initial begin
      int guard;
      wait (drive_done);
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      checks++;
      if (goals_seen == 0 || overs_seen == 0) begin
         failures++;
         $display("FAIL coverage goals=%0d overs=%0d required both nonzero", goals_seen, overs_seen);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #(NCYC * 10 + 5000);
      $display("FAIL timeout reached required=finish");
      $fatal(1);
   end

endmodule
